// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: decouples the PC register from a pipelined, in-order
// instruction memory. The block issues fetch requests only while a credit is
// free, tags each request with the current epoch, and drops responses that
// belong to an epoch a redirect has already cancelled. Surviving responses
// sit in a small circular buffer whose head drives the decode-side outputs.
//
// Handshake rules: a request transfers on a cycle where imem_req_valid and
// imem_req_ready are both high; imem_req_valid never depends on
// imem_req_ready. Responses carry no ready and are always consumed; a
// response seen while nothing is in flight is ignored. The decode head
// transfers on a cycle where valid_d is high and stallD is low.
//
// Optional build macro FETCH_MISALIGN_CHECK_EN adds the fetch_fault output.
// When defined, a PC with nonzero low bits issues no request, holds the PC
// and sets fetch_fault until the next flush or reset.
module instr_fetch_queue #(
    parameter int          XLEN      = 32,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    input  logic            flush,
    input  logic            stallD,
    output logic            stallF,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            valid_d,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus_4_d
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic            fetch_fault
`endif
);

    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    // Tag FIFO: PC and epoch of every request still waiting for its response.
    logic [XLEN-1:0] tag_pc [DEPTH];
    logic            tag_ep [DEPTH];
    logic [AW-1:0]   tag_wr;
    logic [AW-1:0]   tag_rd;
    logic [CW-1:0]   inflight;
    logic            epoch;

    // Output buffer: responses that survived the epoch check.
    logic [31:0]     ob_instr [DEPTH];
    logic [XLEN-1:0] ob_pc    [DEPTH];
    logic [XLEN-1:0] ob_pc4   [DEPTH];
    logic [AW-1:0]   ob_head;
    logic [AW-1:0]   ob_tail;
    logic [CW-1:0]   occupancy;

    logic credit_ok;
    logic misaligned;
    logic accept;
    logic rsp_fire;
    logic rsp_keep;
    logic head_pop;

    // In-flight requests plus buffered words share one pool of DEPTH credits,
    // so a response always finds room in the output buffer.
    assign credit_ok = ({1'b0, inflight} + {1'b0, occupancy}) < DEPTH_W;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misaligned = (pc_in[1:0] != 2'b00) && !flush;
`else
    assign misaligned = 1'b0;
`endif

    assign imem_req_addr  = pc_in;
    assign imem_req_valid = !rst && !flush && !misaligned && credit_ok;
    assign accept         = imem_req_valid && imem_req_ready;
    assign stallF         = !accept && !flush;

    // A response with nothing in flight is a protocol error and is ignored.
    assign rsp_fire = imem_rsp_valid && (inflight != '0);
    assign rsp_keep = rsp_fire && (tag_ep[tag_rd] == epoch) && !flush;

    assign valid_d  = (occupancy != '0);
    assign head_pop = valid_d && !stallD;

    // Decode-side outputs come straight from buffer registers only.
    assign instr_d     = valid_d ? ob_instr[ob_head] : NOP_INSTR;
    assign pc_d        = valid_d ? ob_pc[ob_head]    : '0;
    assign pc_plus_4_d = valid_d ? ob_pc4[ob_head]   : '0;

    // Tag FIFO pointers, in-flight count and the redirect epoch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_wr   <= '0;
            tag_rd   <= '0;
            inflight <= '0;
            epoch    <= 1'b0;
        end else begin
            if (accept)
                tag_wr <= tag_wr + AW'(1);
            if (rsp_fire)
                tag_rd <= tag_rd + AW'(1);
            if (accept && !rsp_fire)
                inflight <= inflight + CW'(1);
            else if (!accept && rsp_fire)
                inflight <= inflight - CW'(1);
            if (flush)
                epoch <= ~epoch;
        end
    end

    // Tag FIFO storage; contents are only read behind a valid pointer.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_pc[tag_wr] <= pc_in;
            tag_ep[tag_wr] <= epoch;
        end
    end

    // Output buffer pointers and occupancy; a redirect empties the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ob_head   <= '0;
            ob_tail   <= '0;
            occupancy <= '0;
        end else if (flush) begin
            ob_head   <= '0;
            ob_tail   <= '0;
            occupancy <= '0;
        end else begin
            if (rsp_keep)
                ob_tail <= ob_tail + AW'(1);
            if (head_pop)
                ob_head <= ob_head + AW'(1);
            if (rsp_keep && !head_pop)
                occupancy <= occupancy + CW'(1);
            else if (!rsp_keep && head_pop)
                occupancy <= occupancy - CW'(1);
        end
    end

    // Output buffer storage: instruction word, its PC and the wrapped PC+4.
    always_ff @(posedge clk) begin
        if (rsp_keep) begin
            ob_instr[ob_tail] <= imem_rsp_data;
            ob_pc[ob_tail]    <= tag_pc[tag_rd];
            ob_pc4[ob_tail]   <= tag_pc[tag_rd] + XLEN'(4);
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // Sticky misalignment flag, cleared by a redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fetch_fault <= 1'b0;
        else if (flush)
            fetch_fault <= 1'b0;
        else if (misaligned)
            fetch_fault <= 1'b1;
    end
`endif

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, which sets the address/PC width.
REQ-002 SHALL have parameter DEPTH, default 2, which sets the maximum number of in-flight requests plus buffered instructions (power of 2, at least 2).
REQ-003 SHALL have parameter NOP_INSTR, default 32'h00000013, the instruction word driven on instr_d when valid_d=0.
REQ-004 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port pc_in, input, XLEN bits: current fetch PC from the PC register.
REQ-007 SHALL have port flush, input, 1 bit: redirect (branch taken); the PC register loads its target this cycle.
REQ-008 SHALL have port stallD, input, 1 bit: decode cannot accept an instruction.
REQ-009 SHALL have port stallF, output, 1 bit: holds the PC register.
REQ-010 SHALL have port imem_req_valid, output, 1 bit: instruction memory request valid.
REQ-011 SHALL have port imem_req_ready, input, 1 bit: memory accepts the request.
REQ-012 SHALL have port imem_req_addr, output, XLEN bits: request address.
REQ-013 SHALL have port imem_rsp_valid, input, 1 bit: response valid; responses return in order and are always accepted.
REQ-014 SHALL have port imem_rsp_data, input, 32 bits: instruction word.
REQ-015 SHALL have ports valid_d (1 bit), instr_d (32 bits), pc_d (XLEN bits) and pc_plus_4_d (XLEN bits), all outputs, forming the decode-side head entry.

Function
REQ-016 SHALL drive imem_req_addr = pc_in and imem_req_valid = !flush && (inflight + occupancy < DEPTH).
REQ-017 SHALL drive stallF = !(imem_req_valid && imem_req_ready) && !flush, so the PC advances only on an accepted request or a redirect.
REQ-018 SHALL, on each accepted request, push {pc_in, epoch} into an in-order tag FIFO of DEPTH entries and increment inflight.
REQ-019 SHALL maintain a 1-bit epoch, toggled on every flush cycle.
REQ-020 SHALL, on each imem_rsp_valid, pop the tag FIFO and decrement inflight; if the tag epoch equals the current epoch and flush=0, it SHALL write {data, pc, pc+4} into the output buffer, otherwise it SHALL discard the response.
REQ-021 SHALL present the output buffer (DEPTH entries, circular) head on the *_d ports; valid_d = occupancy != 0; the head pops when valid_d && !stallD.
REQ-022 SHALL have a latency from response to valid_d of 1 cycle when the buffer is empty, and no combinational path from imem_rsp_* to the *_d outputs.
REQ-023 SHALL, on flush, clear the output buffer (occupancy to 0) at the next edge while stale in-flight entries keep their credit until their responses return.
REQ-024 SHALL handle a simultaneous push and pop on the output buffer with occupancy unchanged.
REQ-025 SHALL handle a simultaneous accept and response with inflight unchanged.
REQ-026 SHALL ignore imem_rsp_valid when inflight=0 (protocol error, no state change).
REQ-027 SHALL compute pc_plus_4_d with modulo 2^XLEN wrap; 32'hFFFFFFFC yields 0.
REQ-028 SHALL drive instr_d=NOP_INSTR and pc_d=0 while valid_d=0.

Reset
REQ-029 SHALL, on rst, asynchronously clear inflight, occupancy, FIFO pointers and epoch, and force valid_d=0, instr_d=NOP_INSTR, pc_d=0 and pc_plus_4_d=0.
REQ-030 SHALL drive imem_req_valid=0 while rst is asserted and SHALL drop any response that arrives in the first cycle after release (inflight=0).

Configuration
REQ-031 SHALL, with FETCH_MISALIGN_CHECK_EN defined, add output fetch_fault (1 bit): when pc_in[1:0]!=0 with flush=0, no request is issued, stallF=1, and fetch_fault sets sticky until the next flush or rst.
REQ-032 SHALL, without FETCH_MISALIGN_CHECK_EN, omit fetch_fault, ignore pc_in[1:0] for checking and pass the address unchanged.

Verification
REQ-033 SHALL be verified by: reset then pc_in=0, ready=1, one-cycle memory -> requests 0,4,8; valid_d rises 2 cycles after first accept with pc_d=0 and pc_plus_4_d=4.
REQ-034 SHALL be verified by: stallD=1 with DEPTH=2 -> after 2 accepts, imem_req_valid=0 and stallF=1; release stallD -> one pop and request resumes the next cycle.
REQ-035 SHALL be verified by: flush while 2 requests are in flight (pc 8 and 12) -> both responses are dropped, valid_d stays 0, and the first valid_d after redirect has pc_d equal to the target (0x100).
REQ-036 SHALL be verified by: imem_req_ready=0 for 5 cycles -> stallF=1 and pc_in held; ready=1 -> single accept of the same address.
REQ-037 SHALL be verified by: rst asserted mid-stream with occupancy 2 -> valid_d=0 within the same cycle (asynchronous), and no output from the pre-reset response arriving after release.
REQ-038 SHALL be verified by: with FETCH_MISALIGN_CHECK_EN defined, pc_in=0x102 -> no request and fetch_fault=1; flush to 0x200 -> fetch_fault=0 and fetch resumes.
